arbitro_rr_fifos: RTL and testbench

- Round-robin arbiter between the N input FIFOs and the N output FIFOs of the FIFO datapath.
- Each cycle it moves at most one word from one non-empty input FIFO to the output FIFO named by the word's destination field.
- It holds off any destination whose almost_full flag is high.
- It is gated by the main state machine's active output: `enable` is driven from active_out.

---
 rtl/arbitro_rr_fifos_pkg.sv | 31 +++
 rtl/arbitro_rr_fifos_rr_selector.sv | 31 +++
 rtl/arbitro_rr_fifos.sv | 114 +++++++++++
 tb/tb_arbitro_rr_fifos.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/arbitro_rr_fifos_pkg.sv
// Shared types and helpers for the FIFO round-robin arbiter.
// State encoding, clog2, DEST_W and destination extraction.
package arbitro_rr_fifos_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        STALL = 2'd2
    } state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < n) r = i + 1;
        return r;
    endfunction

    localparam int N_FIFOS_DEF = 4;
    localparam int DEST_W      = clog2(N_FIFOS_DEF);

    // Destination = top dest_w bits of a data_w-bit word.
    function automatic logic [31:0] dest_of(input logic [31:0] word,
                                            input int data_w,
                                            input int dest_w);
        logic [31:0] mask;
        mask = (32'd1 << dest_w) - 32'd1;
        return (word >> (data_w - dest_w)) & mask;
    endfunction

endpackage

// File: rtl/arbitro_rr_fifos_rr_selector.sv
// Combinational priority scan starting at a rotating pointer.
// Ports: req, start -> one-hot grant, grant_idx, any_grant.
module arbitro_rr_fifos_rr_selector #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx,
    output logic         any_grant
);

    always_comb begin
        logic [W-1:0] idx;
        idx       = '0;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        for (int k = 0; k < N; k++) begin
            // N is a power of 2, so the W-bit add wraps modulo N.
            idx = start + W'(k);
            if (!any_grant && req[idx]) begin
                any_grant  = 1'b1;
                grant_idx  = idx;
                grant[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr_fifos.sv
// Round-robin arbiter moving one word/cycle from input to output FIFOs.
// Ports: clk, reset, enable, in_empty, in_data, out_almost_full ->
//   in_pop (comb), out_push, out_data, grant_id (reg), stall, busy.
// Macro ARB_PRIO_FIJA_EN: fixed priority, input 0 highest, no rr_ptr.
module arbitro_rr_fifos
    import arbitro_rr_fifos_pkg::*;
#(
    parameter  int N_FIFOS = 4,
    parameter  int DATA_W  = 10,
    localparam int DW      = clog2(N_FIFOS)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [N_FIFOS-1:0]        in_empty,
    input  logic [N_FIFOS*DATA_W-1:0] in_data,
    input  logic [N_FIFOS-1:0]        out_almost_full,
    output logic [N_FIFOS-1:0]        in_pop,
    output logic [N_FIFOS-1:0]        out_push,
    output logic [DATA_W-1:0]         out_data,
    output logic [DW-1:0]             grant_id,
    output logic                      stall,
    output logic                      busy
);

    state_t              state, state_n;
    logic [DATA_W-1:0]   heads [N_FIFOS];
    logic [DW-1:0]       dests [N_FIFOS];
    logic [N_FIFOS-1:0]  req;
    logic [N_FIFOS-1:0]  sel_grant;
    logic [DW-1:0]       sel_idx;
    logic                any_req;
    logic                all_empty;
    logic                do_xfer;
    logic [DW-1:0]       start_ptr;
    logic [N_FIFOS-1:0]  push_vec;

    always_comb begin
        for (int i = 0; i < N_FIFOS; i++) begin
            heads[i] = in_data[i*DATA_W +: DATA_W];
            dests[i] = DW'(dest_of(32'(heads[i]), DATA_W, DW));
            req[i]   = !in_empty[i] && !out_almost_full[dests[i]];
        end
    end

    arbitro_rr_fifos_rr_selector #(
        .N (N_FIFOS),
        .W (DW)
    ) u_rr_selector (
        .req       (req),
        .start     (start_ptr),
        .grant     (sel_grant),
        .grant_idx (sel_idx),
        .any_grant (any_req)
    );

    assign all_empty = &in_empty;
    assign do_xfer   = enable && any_req && !reset;
    assign in_pop    = do_xfer ? sel_grant : '0;

    always_comb begin
        push_vec                 = '0;
        push_vec[dests[sel_idx]] = 1'b1;
    end

`ifdef ARB_PRIO_FIJA_EN
    assign start_ptr = '0;
`else
    logic [DW-1:0] rr_ptr;

    assign start_ptr = rr_ptr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_ptr <= '0;
        else if (do_xfer)
            rr_ptr <= sel_idx + DW'(1);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            out_push <= '0;
            out_data <= '0;
            grant_id <= '0;
        end else begin
            state <= state_n;
            if (do_xfer) begin
                out_push <= push_vec;
                out_data <= heads[sel_idx];
                grant_id <= sel_idx;
            end else begin
                out_push <= '0;
            end
        end
    end

    // Every state follows the same exit rule; the state only
    // records which kind of cycle was just seen.
    always_comb begin
        state_n = state;
        if (!enable || all_empty)
            state_n = IDLE;
        else if (any_req)
            state_n = XFER;
        else
            state_n = STALL;
    end

    assign stall = (state == STALL);
    assign busy  = (state == XFER);

endmodule

// File: tb/tb_arbitro_rr_fifos.sv
// Directed self-checking bench for arbitro_rr_fifos.
// Hand-computed expectations for reset, RR order, blocking, wrap, enable.
module tb_arbitro_rr_fifos;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [3:0]  in_empty;
    logic [39:0] in_data;
    logic [3:0]  out_almost_full;
    logic [3:0]  in_pop;
    logic [3:0]  out_push;
    logic [9:0]  out_data;
    logic [1:0]  grant_id;
    logic        stall;
    logic        busy;

    int vectors;
    int miscompares;

    arbitro_rr_fifos #(
        .N_FIFOS (4),
        .DATA_W  (10)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .in_empty        (in_empty),
        .in_data         (in_data),
        .out_almost_full (out_almost_full),
        .in_pop          (in_pop),
        .out_push        (out_push),
        .out_data        (out_data),
        .grant_id        (grant_id),
        .stall           (stall),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [9:0] W0 = {2'd0, 8'h30};
    localparam logic [9:0] W1 = {2'd2, 8'h31};
    localparam logic [9:0] W2 = {2'd3, 8'h32};
    localparam logic [9:0] W3 = {2'd1, 8'h33};
    localparam logic [9:0] A0 = {2'd0, 8'hA0};
    localparam logic [9:0] A1 = {2'd1, 8'hA1};
    localparam logic [9:0] A2 = {2'd2, 8'hA2};
    localparam logic [9:0] A3 = {2'd3, 8'hA3};

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic grant_step(input string tag,
                              input logic [3:0] e_pop,
                              input logic [3:0] e_push,
                              input logic [9:0] e_data,
                              input logic [1:0] e_id);
        #1;
        check({tag, ".pop"}, 32'(in_pop), 32'(e_pop));
        tick();
        check({tag, ".push"}, 32'(out_push), 32'(e_push));
        check({tag, ".data"}, 32'(out_data), 32'(e_data));
        check({tag, ".id"}, 32'(grant_id), 32'(e_id));
        check({tag, ".busy"}, 32'(busy), 32'd1);
    endtask

    initial begin
        vectors         = 0;
        miscompares     = 0;
        reset           = 1'b1;
        enable          = 1'b0;
        in_empty        = 4'hF;
        in_data         = '0;
        out_almost_full = '0;
        tick();
        tick();
        check("rst.push", 32'(out_push), 32'd0);
        check("rst.data", 32'(out_data), 32'd0);
        check("rst.id", 32'(grant_id), 32'd0);
        check("rst.stall", 32'(stall), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        enable   = 1'b1;
        in_empty = 4'h0;
        in_data  = {A3, A2, A1, A0};
        #1;
        check("rst.pop", 32'(in_pop), 32'd0);
        tick();
        reset = 1'b0;

        grant_step("rr0", 4'b0001, 4'b0001, A0, 2'd0);
        grant_step("rr1", 4'b0010, 4'b0010, A1, 2'd1);
        grant_step("rr2", 4'b0100, 4'b0100, A2, 2'd2);
        grant_step("rr3", 4'b1000, 4'b1000, A3, 2'd3);
        grant_step("rr4", 4'b0001, 4'b0001, A0, 2'd0);
        grant_step("rr5", 4'b0010, 4'b0010, A1, 2'd1);

        #2;
        reset = 1'b1;
        #1;
        check("mid.push", 32'(out_push), 32'd0);
        check("mid.data", 32'(out_data), 32'd0);
        check("mid.id", 32'(grant_id), 32'd0);
        check("mid.busy", 32'(busy), 32'd0);
        check("mid.pop", 32'(in_pop), 32'd0);
        tick();
        reset = 1'b0;

        in_data         = {W3, W2, W1, W0};
        in_empty        = 4'b1100;
        out_almost_full = 4'b0100;
        grant_step("blk0", 4'b0001, 4'b0001, W0, 2'd0);
        grant_step("blk1", 4'b0001, 4'b0001, W0, 2'd0);
        check("blk1.stall", 32'(stall), 32'd0);
        in_empty = 4'b1101;
        #1;
        check("stl.pop", 32'(in_pop), 32'd0);
        tick();
        check("stl.stall", 32'(stall), 32'd1);
        check("stl.busy", 32'(busy), 32'd0);
        check("stl.push", 32'(out_push), 32'd0);
        check("stl.hold", 32'(out_data), 32'(W0));
        out_almost_full = 4'b0000;
        grant_step("res", 4'b0010, 4'b0100, W1, 2'd1);
        check("res.stall", 32'(stall), 32'd0);

        in_empty = 4'b1011;
        grant_step("ptr3", 4'b0100, 4'b1000, W2, 2'd2);
        in_empty = 4'b0110;
        grant_step("wrp0", 4'b1000, 4'b0010, W3, 2'd3);
        grant_step("wrp1", 4'b0001, 4'b0001, W0, 2'd0);
        grant_step("wrp2", 4'b1000, 4'b0010, W3, 2'd3);

        grant_step("en0", 4'b0001, 4'b0001, W0, 2'd0);
        enable = 1'b0;
        #1;
        check("en.pop", 32'(in_pop), 32'd0);
        check("en.push", 32'(out_push), 32'b0001);
        tick();
        check("en.push2", 32'(out_push), 32'd0);
        check("en.busy", 32'(busy), 32'd0);
        check("en.stall", 32'(stall), 32'd0);
        check("en.hold", 32'(out_data), 32'(W0));
        check("en.pop2", 32'(in_pop), 32'd0);

        enable   = 1'b1;
        in_empty = 4'b1010;
`ifdef ARB_PRIO_FIJA_EN
        grant_step("fix0", 4'b0001, 4'b0001, W0, 2'd0);
        grant_step("fix1", 4'b0001, 4'b0001, W0, 2'd0);
        grant_step("fix2", 4'b0001, 4'b0001, W0, 2'd0);
`else
        grant_step("alt0", 4'b0100, 4'b1000, W2, 2'd2);
        grant_step("alt1", 4'b0001, 4'b0001, W0, 2'd0);
        grant_step("alt2", 4'b0100, 4'b1000, W2, 2'd2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
